// File: rtl/pipelined_addsub.sv
// Pipelined adder-subtractor: the carry chain is split into STAGES chunks with one
// register stage each, under a global-enable valid/ready stream with backpressure.
`timescale 1ns/1ps
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage-k inputs: index 0 comes from the ports, index k>0 from stage k-1's registers.
    logic             w_vld [STAGES];
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_s   [STAGES];
    logic             w_c   [STAGES];
    logic             w_sat [STAGES];
    logic             w_en;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    assign w_vld[0] = in_valid;
    assign w_a[0]   = a;
    assign w_b[0]   = sub ? ~b : b;
    assign w_c[0]   = sub ^ cin;
    assign w_s[0]   = '0;
    assign w_sat[0] = sat;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   w_add;
        logic [WIDTH-1:0] w_ns;

        assign w_add = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c[k]};

        always_comb begin
            w_ns = w_s[k];
            w_ns[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
        end

        if (k < STAGES-1) begin : g_mid
            logic             r_vld;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;
            logic             r_c;
            logic             r_sat;

            // NOTE: data registers are reset too, so a reset mid-stream leaves no stale operands behind.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_sat <= 1'b0;
                end else if (w_en) begin
                    r_vld <= w_vld[k];
                    r_a   <= w_a[k];
                    r_b   <= w_b[k];
                    r_s   <= w_ns;
                    r_c   <= w_add[CHUNK];
                    r_sat <= w_sat[k];
                end
            end

            assign w_vld[k+1] = r_vld;
            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_s[k+1]   = r_s;
            assign w_c[k+1]   = r_c;
            assign w_sat[k+1] = r_sat;
        end else begin : g_last
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            // Operand signs agree but the raw result sign differs.
            assign w_ovf = (w_a[k][WIDTH-1] == w_b[k][WIDTH-1])
                        && (w_ns[WIDTH-1] != w_a[k][WIDTH-1]);

            always_comb begin
                w_res = w_ns;
                if (w_sat[k] && w_ovf)
                    w_res = w_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_vld <= 1'b0;
                    r_sum     <= '0;
                    r_cout    <= 1'b0;
                    r_ovf     <= 1'b0;
                    r_zero    <= 1'b0;
                    r_neg     <= 1'b0;
                end else if (w_en) begin
                    r_out_vld <= w_vld[k];
                    r_sum     <= w_res;
                    r_cout    <= w_add[CHUNK];
                    r_ovf     <= w_ovf;
                    r_zero    <= (w_res == '0);
                    r_neg     <= w_res[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: a 32-bit/4-stage instance carries the
// directed, stall and reset scenarios; a 16-bit/1-stage instance checks the degenerate pipe.
`timescale 1ns/1ps
module tb_pipelined_addsub;

    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, sat, cout, overflow, zero, negative;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cin16, sub16, sat16, cout16, ovf16, zero16, neg16;

    int   checks = 0;
    int   errors = 0;
    int   retired = 0;
    exp_t q[$];
    exp_t pend;
    bit   last_acc;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .sat(sat16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .cout(cout16),
        .overflow(ovf16), .zero(zero16), .negative(neg16)
    );

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o,
                                input logic z, input logic n);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.neg = n;
        return e;
    endfunction

    // Reference built from exact integer arithmetic rather than the bitwise datapath.
    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic ic, input logic isub, input logic isat);
        longint          sa, sb, r;
        longint unsigned ua, ub, ut;
        exp_t            e;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ua = {32'b0, ia};
        ub = {32'b0, ib};
        r  = isub ? (sa - sb - longint'(ic)) : (sa + sb + longint'(ic));
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (isub) begin
            e.cout = (ua >= ub + {63'b0, ic});
        end else begin
            ut = ua + ub + {63'b0, ic};
            e.cout = ut[32];
        end
        e.sum = r[31:0];
        if (isat && e.ovf) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.zero = (e.sum == 32'h0);
        e.neg  = e.sum[31];
        return e;
    endfunction

    // One cycle from a negedge: record an accept, score a retire, advance to the next negedge.
    task automatic tick();
        exp_t got, e;
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) q.push_back(pend);
        if (out_valid && out_ready) begin
            checks++;
            retired++;
            got = {sum, cout, overflow, zero, negative};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got sum=%h with nothing outstanding", sum);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b n=%b, expected sum=%h c=%b v=%b z=%b n=%b",
                             sum, cout, overflow, zero, negative, e.sum, e.cout, e.ovf, e.zero, e.neg);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        input logic isub, input logic isat, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        a = ia; b = ib; cin = ic; sub = isub; sat = isat;
        pend = e;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        in_valid = 1'b0;
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat a=%h not accepted in 50 cycles", ia);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, overflow, zero, negative, in_ready, out_valid16} !== {1'b0, 32'h0, 4'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b z=%b n=%b rdy=%b v16=%b, expected v=0 sum=0 flags=0 rdy=1 v16=0",
                     out_valid, sum, cout, overflow, zero, negative, in_ready, out_valid16);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b, expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        int lat = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'h0000_FFFF; b = 32'h1; cin = 0; sub = 0; sat = 0;
        pend = mk(32'h0001_0000, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL first_accept: in_ready=%b, expected 1", in_ready);
        end
        #1;
        while (!out_valid && lat < 10) begin
            tick();
            #1;
            lat++;
        end
        checks++;
        if (lat != STAGES-1) begin
            errors++;
            $display("FAIL latency: out_valid after %0d edges past accept, expected %0d", lat, STAGES-1);
        end
        drain();
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        send(32'h7FFF_FFFF, 32'h1, 0, 0, 0, mk(32'h8000_0000, 0, 1, 0, 1));
        send(32'h7FFF_FFFF, 32'h1, 0, 0, 1, mk(32'h7FFF_FFFF, 0, 1, 0, 0));
        send(32'h5,         32'h7, 0, 1, 0, mk(32'hFFFF_FFFE, 0, 0, 0, 1));
        send(32'h8000_0000, 32'h1, 0, 1, 1, mk(32'h8000_0000, 1, 1, 0, 1));
        send(32'h1234,      32'h1234, 0, 1, 0, mk(32'h0, 1, 0, 1, 0));
        send(32'hA,         32'h3, 1, 1, 0, mk(32'h6, 1, 0, 0, 0));
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0, mk(32'h0, 1, 0, 1, 0));
        send(32'h8000_0000, 32'h8000_0000, 0, 0, 1, mk(32'h8000_0000, 1, 1, 0, 1));
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra[8], rb[8];
        logic        rc[8], rs[8], rt[8];
        logic [31:0] held = '0;
        int          sent = 0, cyc = 0, base;
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
            rc[i] = 1'($urandom_range(1)); rs[i] = 1'($urandom_range(1)); rt[i] = 1'($urandom_range(1));
        end
        base = retired;
        while ((sent < 8 || q.size() > 0) && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a = ra[sent]; b = rb[sent]; cin = rc[sent]; sub = rs[sent]; sat = rt[sent];
                pend = model(ra[sent], rb[sent], rc[sent], rs[sent], rt[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall: cycle %0d in_ready=%b out_valid=%b, expected 0 and 1", cyc, in_ready, out_valid);
                end
                if (cyc > 5) begin
                    checks++;
                    if (sum !== held) begin
                        errors++;
                        $display("FAIL stall_hold: cycle %0d sum=%h, expected held %h", cyc, sum, held);
                    end
                end
                held = sum;
            end else if (sent < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bubble: cycle %0d in_ready=%b with out_ready=1, expected 1", cyc, in_ready);
                end
            end
            tick();
            if (last_acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 8 || retired - base != 8) begin
            errors++;
            $display("FAIL stream_count: sent=%0d retired=%0d, expected 8 and 8", sent, retired - base);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send(32'h100 + 32'(i), 32'h1, 0, 0, 0, mk(32'h101 + 32'(i), 0, 0, 0, 0));
        out_ready = 1'b0;
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: out_valid=%b, expected 1", out_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || clk !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b clk=%b, expected 0 before any edge", out_valid, clk);
        end
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset: cycle %0d out_valid=%b sum=%h, expected 0", i, out_valid, sum);
            end
            tick();
        end
        send(32'hDEAD_0000, 32'h0000_BEEF, 1, 0, 0, mk(32'hDEAD_BEF0, 0, 0, 0, 1));
        drain();
    endtask

    task automatic test_w16();
        in_valid16 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; sub16 = 1'b0; sat16 = 1'b0;
        out_ready16 = 1'b1;
        #1;
        checks++;
        if (in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL w16_ready: in_ready=%b, expected 1", in_ready16);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        checks++;
        if ({out_valid16, sum16, cout16, ovf16, zero16, neg16} !== {1'b1, 16'h0001, 4'b1000}) begin
            errors++;
            $display("FAIL w16_result: got v=%b sum=%h c=%b o=%b z=%b n=%b, expected v=1 sum=0001 c=1 o=0 z=0 n=0",
                     out_valid16, sum16, cout16, ovf16, zero16, neg16);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_retire: out_valid=%b, expected 0", out_valid16);
        end
    endtask

    initial begin
        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0; sat = 0;
        in_valid16 = 0; out_ready16 = 1; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; sat16 = 0;
        pend = '0;
        last_acc = 1'b0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_w16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
